// File: rtl/merge_nx1_arbiter_seq.sv
// N-to-1 merge: arbitrates among valid inputs (fixed / round-robin / burst-locked)
// and captures the winner, tagged with its index, in a one-entry back-pressured register.
module merge_nx1_arbiter_seq #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_INPUT     = 4,
  parameter int COMMAND_WIDTH = 2,
  parameter int SEL_WIDTH     = $clog2(NUM_INPUT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_INPUT-1:0]            i_valid,
  input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data_bus,
  output logic [NUM_INPUT-1:0]            o_ready,
  input  logic                            i_ready,
  output logic                            o_valid,
  output logic [SEL_WIDTH+DATA_WIDTH-1:0] o_data_bus,
  input  logic                            i_en,
  input  logic [COMMAND_WIDTH-1:0]        i_cmd
);

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_LOCK  = 2'd2
  } mode_t;

  mode_t                  mode;
  logic [SEL_WIDTH-1:0]   rr_ptr;
  logic                   lock_vld;
  logic [SEL_WIDTH-1:0]   lock_idx;

  logic [NUM_INPUT-1:0]   ge_mask;
  logic [NUM_INPUT-1:0]   rr_upper;
  logic [SEL_WIDTH-1:0]   rr_win;
  logic [NUM_INPUT-1:0]   lock_oh;
  logic                   lock_live;
  logic                   lock_hit;
  logic [SEL_WIDTH-1:0]   winner;
  logic [NUM_INPUT-1:0]   grant_oh;
  logic [DATA_WIDTH-1:0]  win_word;
  logic [SEL_WIDTH-1:0]   next_ptr;
  logic                   load_opp;
  logic                   load;

  function automatic logic [SEL_WIDTH-1:0] lowest_idx(input logic [NUM_INPUT-1:0] v);
    lowest_idx = '0;
    for (int k = NUM_INPUT - 1; k >= 0; k--)
      if (v[k]) lowest_idx = SEL_WIDTH'(k);
  endfunction

  function automatic logic [NUM_INPUT-1:0] to_onehot(input logic [SEL_WIDTH-1:0] idx);
    to_onehot = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      to_onehot[k] = (idx == SEL_WIDTH'(k));
  endfunction

  // Unlisted command codes fall back to fixed priority.
  always_comb begin
    mode = MODE_FIXED;
    if (i_cmd == COMMAND_WIDTH'(1))      mode = MODE_RR;
    else if (i_cmd == COMMAND_WIDTH'(2)) mode = MODE_LOCK;
  end

  // Wrapping search from rr_ptr: prefer channels at or above the pointer, else wrap to the lowest.
  always_comb begin
    ge_mask = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      ge_mask[k] = (SEL_WIDTH'(k) >= rr_ptr);
  end

  assign rr_upper  = i_valid & ge_mask;
  assign rr_win    = (|rr_upper) ? lowest_idx(rr_upper) : lowest_idx(i_valid);
  assign lock_oh   = to_onehot(lock_idx);
  assign lock_live = |(i_valid & lock_oh);
  assign lock_hit  = lock_vld & lock_live;

  always_comb begin
    winner = lowest_idx(i_valid);
    case (mode)
      MODE_RR:   winner = rr_win;
      MODE_LOCK: winner = lock_hit ? lock_idx : rr_win;
      default:   winner = lowest_idx(i_valid);
    endcase
  end

  assign grant_oh = to_onehot(winner);
  assign load_opp = ~rst & i_en & (~o_valid | i_ready);
  assign load     = load_opp & (|i_valid);
  assign o_ready  = load ? grant_oh : '0;
  assign next_ptr = (winner == SEL_WIDTH'(NUM_INPUT - 1)) ? '0 : winner + SEL_WIDTH'(1);

  always_comb begin
    win_word = '0;
    for (int k = 0; k < NUM_INPUT; k++)
      if (grant_oh[k]) win_word = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid    <= 1'b0;
      o_data_bus <= '0;
      rr_ptr     <= '0;
      lock_vld   <= 1'b0;
      lock_idx   <= '0;
    end else begin
      if (load) begin
        o_valid    <= 1'b1;
        o_data_bus <= {winner, win_word};
      end else if (o_valid && i_ready) begin
        o_valid    <= 1'b0;
      end

      if (load && mode != MODE_FIXED)
        rr_ptr <= next_ptr;

      // A fresh lock takes precedence over releasing the stale one.
      if (mode != MODE_LOCK) begin
        lock_vld <= 1'b0;
      end else if (load && !lock_hit) begin
        lock_vld <= 1'b1;
        lock_idx <= winner;
      end else if (load_opp && !lock_live) begin
        lock_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merge_nx1_arbiter_seq.sv
// Table-driven bench for merge_nx1_arbiter_seq with a scoreboard queue for
// the registered output word.
module tb_merge_nx1_arbiter_seq;
  localparam int DW = 32;
  localparam int NI = 4;
  localparam int CW = 2;
  localparam int SW = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NI-1:0]      i_valid;
  logic [NI*DW-1:0]   i_data_bus;
  logic [NI-1:0]      o_ready;
  logic               i_ready;
  logic               o_valid;
  logic [SW+DW-1:0]   o_data_bus;
  logic               i_en;
  logic [CW-1:0]      i_cmd;

  merge_nx1_arbiter_seq #(
    .DATA_WIDTH(DW), .NUM_INPUT(NI), .COMMAND_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_data_bus(i_data_bus),
    .o_ready(o_ready), .i_ready(i_ready), .o_valid(o_valid),
    .o_data_bus(o_data_bus), .i_en(i_en), .i_cmd(i_cmd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] cmd;
    logic [3:0] valid;
    logic       irdy;
    logic [3:0] exp_ready;
    logic       exp_ov;
  } vec_t;

  vec_t              vecs[29];
  logic [SW+DW-1:0]  sb[$];
  logic [SW+DW-1:0]  exp_bus;
  int                n_cmp = 0;
  int                n_err = 0;
  int                cur_step = 0;

  function automatic vec_t mk(input logic rs, input logic en, input logic [1:0] cm,
                              input logic [3:0] v, input logic ir,
                              input logic [3:0] er, input logic eo);
    vec_t r;
    r.rst = rs; r.en = en; r.cmd = cm; r.valid = v; r.irdy = ir;
    r.exp_ready = er; r.exp_ov = eo;
    return r;
  endfunction

  // Payload changes every step so held/stale words are distinguishable.
  function automatic logic [DW-1:0] word_of(input int step, input int ch);
    logic [3:0]  c;
    logic [7:0]  s;
    logic [15:0] f;
    c = 4'(ch);
    s = 8'(step);
    f = 16'(ch * 16'h1111);
    return {c, 4'hA, s, f};
  endfunction

  function automatic logic [SW-1:0] idx_of(input logic [3:0] oh);
    logic [SW-1:0] r;
    r = '0;
    for (int k = 0; k < NI; k++)
      if (oh[k]) r = SW'(k);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %h expected %h", name, cur_step, act, exp);
    end
  endtask

  task automatic run_row(input vec_t r);
    logic [SW-1:0] gi;
    @(negedge clk);
    rst     = r.rst;
    i_en    = r.en;
    i_cmd   = r.cmd;
    i_valid = r.valid;
    i_ready = r.irdy;
    for (int k = 0; k < NI; k++)
      i_data_bus[k*DW +: DW] = word_of(cur_step, k);
    #1;
    check("o_ready", 64'(o_ready), 64'(r.exp_ready));
    if (r.exp_ready != 4'b0000) begin
      gi = idx_of(r.exp_ready);
      sb.push_back({gi, word_of(cur_step, int'(gi))});
    end
    @(posedge clk);
    #1;
    if (r.rst) begin
      exp_bus = '0;
    end else if (r.exp_ready != 4'b0000) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard step %0d: got empty queue expected one entry", cur_step);
      end else begin
        exp_bus = sb.pop_front();
      end
    end
    check("o_valid", 64'(o_valid), 64'(r.exp_ov));
    check("o_data_bus", 64'(o_data_bus), 64'(exp_bus));
    cur_step++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_en = 1'b0; i_cmd = '0; i_valid = '0; i_ready = 1'b0;
    i_data_bus = '0; exp_bus = '0;

    //              rst en cmd  valid   irdy  ready    ov
    vecs[0]  = mk(1, 1, 2'd0, 4'b1111, 1, 4'b0000, 0);
    vecs[1]  = mk(0, 1, 2'd0, 4'b1010, 1, 4'b0010, 1);
    vecs[2]  = mk(0, 1, 2'd0, 4'b1000, 1, 4'b1000, 1);
    vecs[3]  = mk(0, 1, 2'd0, 4'b0000, 1, 4'b0000, 0);
    vecs[4]  = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0001, 1);
    vecs[5]  = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0010, 1);
    vecs[6]  = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0100, 1);
    vecs[7]  = mk(0, 1, 2'd1, 4'b1111, 1, 4'b1000, 1);
    vecs[8]  = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0001, 1);
    vecs[9]  = mk(0, 1, 2'd1, 4'b1111, 0, 4'b0000, 1);
    vecs[10] = mk(0, 1, 2'd1, 4'b1111, 0, 4'b0000, 1);
    vecs[11] = mk(0, 1, 2'd1, 4'b1111, 0, 4'b0000, 1);
    vecs[12] = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0010, 1);
    vecs[13] = mk(0, 1, 2'd2, 4'b0101, 1, 4'b0100, 1);
    vecs[14] = mk(0, 1, 2'd2, 4'b0101, 1, 4'b0100, 1);
    vecs[15] = mk(0, 1, 2'd2, 4'b0101, 1, 4'b0100, 1);
    vecs[16] = mk(0, 1, 2'd2, 4'b0001, 1, 4'b0001, 1);
    vecs[17] = mk(0, 0, 2'd2, 4'b0001, 0, 4'b0000, 1);
    vecs[18] = mk(0, 0, 2'd2, 4'b0001, 1, 4'b0000, 0);
    vecs[19] = mk(0, 1, 2'd2, 4'b0001, 1, 4'b0001, 1);
    vecs[20] = mk(0, 1, 2'd2, 4'b0000, 1, 4'b0000, 0);
    vecs[21] = mk(0, 1, 2'd1, 4'b0010, 1, 4'b0010, 1);
    vecs[22] = mk(1, 1, 2'd1, 4'b1111, 1, 4'b0000, 0);
    vecs[23] = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0001, 1);
    vecs[24] = mk(0, 1, 2'd3, 4'b1110, 1, 4'b0010, 1);
    vecs[25] = mk(0, 1, 2'd1, 4'b1111, 1, 4'b0010, 1);
    vecs[26] = mk(0, 1, 2'd2, 4'b1000, 1, 4'b1000, 1);
    vecs[27] = mk(0, 1, 2'd0, 4'b1001, 1, 4'b0001, 1);
    vecs[28] = mk(0, 1, 2'd2, 4'b1001, 1, 4'b0001, 1);

    for (int i = 0; i < 29; i++)
      run_row(vecs[i]);

    // Sustained round-robin after a fresh reset: rotation from ch0, one word per cycle.
    run_row(mk(1, 1, 2'd1, 4'b1111, 1, 4'b0000, 0));
    for (int i = 0; i < 12; i++)
      run_row(mk(0, 1, 2'd1, 4'b1111, 1, 4'(1 << (i % 4)), 1));

    // Stall with changing payloads, then release: replacement in the release cycle.
    run_row(mk(0, 1, 2'd1, 4'b1111, 0, 4'b0000, 1));
    run_row(mk(0, 1, 2'd1, 4'b1111, 0, 4'b0000, 1));
    run_row(mk(0, 1, 2'd1, 4'b1111, 1, 4'b0001, 1));
    run_row(mk(0, 1, 2'd1, 4'b0000, 1, 4'b0000, 0));

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
